// File: rtl/soc_timer.sv
// soc_timer: memory-mapped down-counting timer on the picoRV32 native bus.
//
// Register map (word index on addr):
//   0 CTRL   bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable)
//   1 PRESC  prescaler divide value (PRESC_WIDTH bits)
//   2 LOAD   reload value
//   3 COUNT  current count (read/write)
//   4 STATUS bit0 EXP, sticky, write 1 to clear
//   5..7     read 0, writes ignored
//
// Ports:
//   clk    system clock
//   resetn asynchronous active-low reset
//   sel    bus request for the timer window, held until ready
//   addr   word index (mem_addr[4:2])
//   wdata  write data
//   wstrb  byte write strobes, 4'b0000 = read
//   rdata  registered read data, valid while ready=1
//   ready  single-cycle transfer acknowledge
//   irq    level interrupt, registered (EXP && IE)
module soc_timer #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        irq
);

    logic                   en;
    logic                   auto_rl;
    logic                   ie;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] pcnt;
    logic [31:0]            load;
    logic [31:0]            count;
    logic                   expf;
    logic                   idle_seen;

    logic                   xfer;
    logic                   wr;
    logic                   tick;
    logic                   expire;
    logic [31:0]            rd_val;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] din,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = din[b*8 +: 8];
        end
        return r;
    endfunction

    // A request still pending across a reset must be dropped by the master
    // before it is served; idle_seen records that sel has been low since reset.
    assign xfer   = sel && !ready && idle_seen;
    assign wr     = xfer && (wstrb != 4'b0000);
    assign tick   = en && (pcnt == presc);
    assign expire = tick && (count == 32'd0);

    always_comb begin
        rd_val = 32'd0;
        case (addr)
            3'd0:    rd_val = {29'd0, ie, auto_rl, en};
            3'd1:    rd_val = 32'(presc);
            3'd2:    rd_val = load;
            3'd3:    rd_val = count;
            3'd4:    rd_val = {31'd0, expf};
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en        <= 1'b0;
            auto_rl   <= 1'b0;
            ie        <= 1'b0;
            presc     <= '0;
            pcnt      <= '0;
            load      <= 32'd0;
            count     <= 32'd0;
            expf      <= 1'b0;
            idle_seen <= 1'b0;
            rdata     <= 32'd0;
            ready     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            ready     <= xfer;
            idle_seen <= idle_seen | !sel;
            irq       <= expf && ie;
            if (xfer) rdata <= rd_val;

            // Prescaler: held at 0 while disabled, so enabling always starts
            // a full PRESC+1 period.
            if (!en || tick) pcnt <= '0;
            else             pcnt <= pcnt + 1'b1;

            if (tick) begin
                if (count != 32'd0) begin
                    count <= count - 32'd1;
                end else begin
                    expf <= 1'b1;
                    if (auto_rl) count <= load;
                    else         en    <= 1'b0;
                end
            end

            // Bus writes come last so they override the counter updates
            // above; the STATUS clear is the exception (expiry wins).
            if (wr) begin
                case (addr)
                    3'd0: if (wstrb[0]) {ie, auto_rl, en} <= wdata[2:0];
                    3'd1: presc <= PRESC_WIDTH'(merge_bytes(32'(presc), wdata, wstrb));
                    3'd2: load  <= merge_bytes(load, wdata, wstrb);
                    3'd3: count <= merge_bytes(count, wdata, wstrb);
                    3'd4: if (wstrb[0] && wdata[0] && !expire) expf <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule
